eq_biquad_sequencer: RTL and testbench
======================================

Name: eq_biquad_sequencer

Overview:
Time-multiplexed controller for the tone-control EQ.
- Runs N_STAGES cascaded Q4.28 biquads (stage 0 = bass shelf, stage 1 = treble shelf) on one shared 32x16 signed multiplier-accumulator.
- Sequences the five MACs per stage, owns the per-stage x/y history registers and snapshots coefficients per sample.
- Accepts one sample at a time with a ready/valid handshake. Sits between the audio sample source and the effect chain.

Parameters:
N_STAGES, 2, number of cascaded biquad stages (1..4)
COEF_W, 32, coefficient width, Q4.28 signed
DATA_W, 16, sample width, signed
ACC_W, 52, accumulator width

Ports:
i_clk  input  1  system clock, single clock domain
i_rst  input  1  synchronous reset, active-high
i_enable  input  1  1 = filter, 0 = bypass
i_valid  input  1  input sample strobe
i_data  input  16  signed input sample
i_coef  input  N_STAGES*5*32  per stage s, packed low-to-high: a0,a1,a2,b1,b2
o_ready  output  1  high only in IDLE; a sample is accepted when i_valid && o_ready
o_data  output  16  signed filtered sample, held until the next o_valid
o_valid  output  1  one-cycle pulse with o_data
o_overrun  output  1  one-cycle pulse when i_valid arrives while o_ready is low

Behaviour:
- Reset: all outputs except o_ready are 0; o_ready = 1. FSM goes to IDLE. All history registers, the accumulator and the stage/tap counters clear. A reset mid-sequence aborts the sample with no o_valid.
- Per-stage equation: y = a0*x + a1*x1 + a2*x2 - b1*y1 - b2*y2.
- FSM states: IDLE -> MAC -> WB -> (MAC for the next stage | DONE) -> IDLE.
- IDLE: on accept, latch i_data into x_cur and snapshot all of i_coef. Coefficient changes after this take effect on the next sample only. Clear acc, stage=0, tap=0.
- MAC: 5 cycles, tap 0..4.
  - Each cycle acc += coef[tap]*operand[tap], using a full 48-bit signed product sign-extended to ACC_W.
  - Operands are x_cur, x1[s], x2[s], y1[s], y2[s].
  - Taps 3 and 4 subtract instead of add.
- WB: 1 cycle.
  - y = acc >>> 28 (arithmetic shift, truncation toward -inf), saturated to [-32768, 32767].
  - Update history: x2[s]<=x1[s], x1[s]<=x_cur, y2[s]<=y1[s], y1[s]<=y.
  - Then x_cur<=y, acc<=0, stage++.
  - If stage == N_STAGES-1, go to DONE, else go to MAC.
- DONE: o_data <= final y, o_valid = 1 for one cycle, go to IDLE.
- Latency: accept at cycle t gives o_valid at t + 6*N_STAGES + 1 (13 for N_STAGES=2). The next accept is possible at t+14.
- Bypass (i_enable=0 when the sample is accepted):
  - o_data <= i_data and o_valid pulses at t+1.
  - All history registers are cleared, so re-enabling starts from zero state.
  - i_enable is sampled only at accept and ignored mid-sequence.
- Overrun: i_valid while o_ready=0 pulses o_overrun at the next cycle. The sample is dropped and the sequence and history are unaffected.
- i_valid in the same cycle o_ready rises (IDLE) is accepted normally.
- Saturation applies at every stage output, not only the final one.

Decomposition:
- Shared package eq_pkg holds:
  - COEF_FRAC=28 and the tap-index enum (TAP_A0..TAP_B2).
  - The FSM state enum (S_IDLE, S_MAC, S_WB, S_DONE).
  - A packed struct biquad_coef_t {a0,a1,a2,b1,b2}.
  - The sat16 function.
- One sub-module, eq_mac_unit, registers the signed 32x16 multiply and accumulate, with clear, add/sub select and a 52-bit accumulator. The FSM, history registers and handshake stay in the top.

Test Plan:
1. Identity: a0=268435456 and others 0 for both stages. Send 1000, then -2500 → o_data=1000 at accept+13, then -2500. o_ready is low for 13 cycles after each accept.
2. Impulse, stage 0 only: a0=0, a1=134217728 (0.5); stage 1 identity. Send 16000, 0, 0 → outputs 0, 8000, 0.
3. Recursion: stage 0 a0=268435456, b1=-134217728 (y+=0.5*y1); stage 1 identity. Send 1024, 0, 0 → 1024, 512, 256.
4. Saturation: stage 0 a0=1073741823 (≈4.0). Send 16000 → 32767; send -16000 → -32768.
5. Overrun and reset: assert i_valid 3 cycles after an accept → o_overrun pulse and identical output. Assert i_rst at accept+5 → no o_valid, o_ready=1 next cycle, and the history is zero (the next impulse output matches test 2).
6. Bypass: i_enable=0, send -7 → o_data=-7 at accept+1. Re-enable with test 3 coefficients → the response starts from clean history.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and helpers for the tone-control EQ biquad sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package eq_pkg;

    // Coefficients are Q4.28, so products are rescaled by this many bits.
    localparam int COEF_FRAC = 28;
    localparam int ACC_W_DEF = 52;

    typedef enum logic [2:0] {
        TAP_A0 = 3'd0,
        TAP_A1 = 3'd1,
        TAP_A2 = 3'd2,
        TAP_B1 = 3'd3,
        TAP_B2 = 3'd4
    } tap_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Declared MSB-first so a0 lands in the lowest 32 bits, matching the
    // low-to-high packing of each stage's slice of i_coef.
    typedef struct packed {
        logic signed [31:0] b2;
        logic signed [31:0] b1;
        logic signed [31:0] a2;
        logic signed [31:0] a1;
        logic signed [31:0] a0;
    } biquad_coef_t;

    localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = 52'sd32767;
    localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = -52'sd32768;

    // Clamp a rescaled accumulator value to the signed 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W_DEF-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/eq_mac_unit.sv
// Shared signed COEF_W x DATA_W multiply feeding a registered ACC_W accumulator.
// Latency: acc reflects an add/sub one cycle after i_en; clear takes effect next cycle.
// Backpressure: none; the sequencer drives i_en/i_clr every cycle.
// Ports: i_clk/i_rst (sync, active-high), i_clr (zero acc, wins over i_en),
//        i_en (accumulate this cycle), i_sub (subtract instead of add),
//        i_coef/i_data (multiplier operands), o_acc (accumulator value).
module eq_mac_unit #(
    parameter int COEF_W = 32,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 52
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_sub,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = COEF_W + DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Full-precision product, sign-extended so five taps cannot overflow.
    assign prod     = i_coef * i_data;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = i_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/eq_biquad_sequencer.sv
// Time-multiplexed cascade of N_STAGES Q4.28 biquads on one shared MAC.
// Latency: o_valid 6*N_STAGES+1 cycles after accept (1 cycle in bypass).
// Backpressure: o_ready only in IDLE; i_valid while busy is dropped and flagged on o_overrun.
// Ports: i_clk/i_rst (sync, active-high), i_enable (1 filter / 0 bypass),
//        i_valid/i_data/o_ready (sample in), i_coef (per stage a0,a1,a2,b1,b2 low-to-high),
//        o_valid/o_data (filtered sample out), o_overrun (dropped-sample pulse).
module eq_biquad_sequencer
    import eq_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int COEF_W   = 32,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 52
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic                         i_valid,
    input  logic signed [DATA_W-1:0]     i_data,
    input  logic [N_STAGES*5*COEF_W-1:0] i_coef,
    output logic                         o_ready,
    output logic signed [DATA_W-1:0]     o_data,
    output logic                         o_valid,
    output logic                         o_overrun
);

    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

    state_e                   state_q, state_d;
    tap_e                     tap_q, tap_d;
    logic [SW-1:0]            stage_q, stage_d;

    biquad_coef_t             coef_q [N_STAGES];
    biquad_coef_t             coef_d [N_STAGES];
    logic signed [DATA_W-1:0] x1_q [N_STAGES];
    logic signed [DATA_W-1:0] x1_d [N_STAGES];
    logic signed [DATA_W-1:0] x2_q [N_STAGES];
    logic signed [DATA_W-1:0] x2_d [N_STAGES];
    logic signed [DATA_W-1:0] y1_q [N_STAGES];
    logic signed [DATA_W-1:0] y1_d [N_STAGES];
    logic signed [DATA_W-1:0] y2_q [N_STAGES];
    logic signed [DATA_W-1:0] y2_d [N_STAGES];
    logic signed [DATA_W-1:0] x_cur_q, x_cur_d;
    logic signed [DATA_W-1:0] o_data_q, o_data_d;
    logic                     ovr_q, ovr_d;

    logic                     accept;
    logic                     last_stage;
    logic                     mac_clr, mac_en, mac_sub;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_opnd;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [DATA_W-1:0] y_wb;

    assign accept     = i_valid && (state_q == S_IDLE);
    assign last_stage = (stage_q == LAST_STAGE);
    // Arithmetic shift floors toward -inf before the clamp.
    assign acc_sh     = acc >>> COEF_FRAC;
    assign y_wb       = sat16(acc_sh);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            tap_q   <= TAP_A0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        stage_d = stage_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_sub = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mac_clr = 1'b1;
                    tap_d   = TAP_A0;
                    stage_d = '0;
                    // Bypass skips the MAC pass and presents the sample next cycle.
                    state_d = i_enable ? S_MAC : S_DONE;
                end
            end
            S_MAC: begin
                mac_en  = 1'b1;
                // Feedback taps carry the minus sign of the difference equation.
                mac_sub = (tap_q == TAP_B1) || (tap_q == TAP_B2);
                if (tap_q == TAP_B2) begin
                    tap_d   = TAP_A0;
                    state_d = S_WB;
                end else begin
                    tap_d = tap_e'(tap_q + 3'd1);
                end
            end
            S_WB: begin
                mac_clr = 1'b1;
                if (last_stage) begin
                    state_d = S_DONE;
                end else begin
                    stage_d = stage_q + SW'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- MAC operand select ----------------
    always_comb begin
        mac_coef = coef_q[stage_q].a0;
        mac_opnd = x_cur_q;
        case (tap_q)
            TAP_A1: begin
                mac_coef = coef_q[stage_q].a1;
                mac_opnd = x1_q[stage_q];
            end
            TAP_A2: begin
                mac_coef = coef_q[stage_q].a2;
                mac_opnd = x2_q[stage_q];
            end
            TAP_B1: begin
                mac_coef = coef_q[stage_q].b1;
                mac_opnd = y1_q[stage_q];
            end
            TAP_B2: begin
                mac_coef = coef_q[stage_q].b2;
                mac_opnd = y2_q[stage_q];
            end
            default: ;
        endcase
    end

    eq_mac_unit #(
        .COEF_W (COEF_W),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (mac_clr),
        .i_en   (mac_en),
        .i_sub  (mac_sub),
        .i_coef (mac_coef),
        .i_data (mac_opnd),
        .o_acc  (acc)
    );

    // ---------------- Datapath next state ----------------
    always_comb begin
        coef_d   = coef_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        y1_d     = y1_q;
        y2_d     = y2_q;
        x_cur_d  = x_cur_q;
        o_data_d = o_data_q;
        // A busy-time strobe is dropped; only the flag records it.
        ovr_d    = i_valid && (state_q != S_IDLE);

        if (accept) begin
            x_cur_d = i_data;
            // Snapshot so coefficient writes mid-sequence only affect the next sample.
            for (int s = 0; s < N_STAGES; s++) begin
                coef_d[s] = i_coef[s*5*COEF_W +: 5*COEF_W];
            end
            if (!i_enable) begin
                o_data_d = i_data;
                // Re-enabling later starts the filters from rest.
                for (int s = 0; s < N_STAGES; s++) begin
                    x1_d[s] = '0;
                    x2_d[s] = '0;
                    y1_d[s] = '0;
                    y2_d[s] = '0;
                end
            end
        end

        if (state_q == S_WB) begin
            x2_d[stage_q] = x1_q[stage_q];
            x1_d[stage_q] = x_cur_q;
            y2_d[stage_q] = y1_q[stage_q];
            y1_d[stage_q] = y_wb;
            // Stage output becomes the next stage's input.
            x_cur_d       = y_wb;
            if (last_stage) begin
                o_data_d = y_wb;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < N_STAGES; s++) begin
                coef_q[s] <= '0;
                x1_q[s]   <= '0;
                x2_q[s]   <= '0;
                y1_q[s]   <= '0;
                y2_q[s]   <= '0;
            end
            x_cur_q  <= '0;
            o_data_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            coef_q   <= coef_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            y1_q     <= y1_d;
            y2_q     <= y2_d;
            x_cur_q  <= x_cur_d;
            o_data_q <= o_data_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = (state_q == S_DONE);
    assign o_data    = o_data_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_eq_biquad_sequencer.sv
// Self-checking bench for eq_biquad_sequencer (N_STAGES=2).
// Directed table of expected samples, hand sequences for overrun/reset, random vs. reference model.
// Samples outputs 1 time unit after each rising edge; drives inputs at the same point.
module tb_eq_biquad_sequencer;

    logic               i_clk;
    logic               i_rst;
    logic               i_enable;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic [319:0]       i_coef;
    logic               o_ready;
    logic signed [15:0] o_data;
    logic               o_valid;
    logic               o_overrun;

    eq_biquad_sequencer #(
        .N_STAGES (2),
        .COEF_W   (32),
        .DATA_W   (16),
        .ACC_W    (52)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_enable  (i_enable),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_coef    (i_coef),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_overrun (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int failures;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model: direct-form-I biquads in plain integers ----------------
    longint mx1 [2];
    longint mx2 [2];
    longint my1 [2];
    longint my2 [2];

    function automatic void model_clear();
        for (int s = 0; s < 2; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    function automatic longint cf(logic [319:0] c, int s, int k);
        logic signed [31:0] v;
        v = c[(s*5+k)*32 +: 32];
        return longint'(v);
    endfunction

    function automatic int model_step(logic [319:0] c, int d, bit en);
        longint x, acc, y;
        if (!en) begin
            model_clear();
            return d;
        end
        x = d;
        for (int s = 0; s < 2; s++) begin
            acc = cf(c, s, 0) * x + cf(c, s, 1) * mx1[s] + cf(c, s, 2) * mx2[s]
                - cf(c, s, 3) * my1[s] - cf(c, s, 4) * my2[s];
            y = acc >>> 28;
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
            mx2[s] = mx1[s]; mx1[s] = x;
            my2[s] = my1[s]; my1[s] = y;
            x = y;
        end
        return int'(x);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [4:0][31:0] cset(int a0, int a1, int a2, int b1, int b2);
        logic [4:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = b1; r[4] = b2;
        return r;
    endfunction

    function automatic logic [319:0] rand_coef();
        logic [319:0] r;
        logic signed [31:0] v;
        for (int k = 0; k < 10; k++) begin
            v = $urandom;
            v = v >>> 3;
            r[k*32 +: 32] = v;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        model_clear();
    endtask

    // Offers one sample and tracks the response for up to 40 cycles.
    // k counts cycles after the accepting edge; ovr_k/rst_k inject a strobe/reset at cycle k.
    task automatic run_sample(input logic signed [15:0] d, input bit en,
                              input int ovr_k, input int rst_k,
                              input bit chg, input logic [319:0] newc,
                              output int got, output int lat, output int rdy_k,
                              output int nvld, output bit ovr_ok);
        int w;
        got = 0; lat = 0; rdy_k = 0; nvld = 0; ovr_ok = 1'b1;
        w = 0;
        while (!o_ready && w < 20) begin
            step();
            w++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_wait: got o_ready=0 expected 1 within 20 cycles");
        end
        i_data   = d;
        i_enable = en;
        i_valid  = 1'b1;
        step();
        i_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (o_valid) begin
                nvld++;
                if (lat == 0) begin
                    lat = k;
                    got = int'(o_data);
                end
            end
            if (o_ready && rdy_k == 0) rdy_k = k;
            if (ovr_k > 0 && k == ovr_k + 1) begin
                if (!o_overrun) ovr_ok = 1'b0;
            end else if (o_overrun) begin
                ovr_ok = 1'b0;
            end
            i_valid = (k == ovr_k);
            if (k == ovr_k) i_data = 16'sd12345;
            i_rst = (k == rst_k);
            if (chg && k == 2) i_coef = newc;
            if (rdy_k != 0) break;
            step();
        end
        i_valid = 1'b0;
        i_rst   = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic               rst;
        logic               en;
        logic [4:0][31:0]   c0;
        logic [4:0][31:0]   c1;
        logic signed [15:0] d;
        logic signed [15:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    logic [4:0][31:0] cid, cimp, crec, csat, cqtr;
    int    got, lat, rdy_k, nvld;
    bit    ovr_ok;
    logic [319:0] cur_coef, new_coef;
    logic signed [15:0] rd;
    bit    ren, rchg;
    int    exp_y;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        i_rst    = 1'b1;
        i_enable = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_coef   = '0;

        cid  = cset(268435456, 0, 0, 0, 0);
        cimp = cset(0, 134217728, 0, 0, 0);
        crec = cset(268435456, 0, 0, -134217728, 0);
        csat = cset(1073741823, 0, 0, 0, 0);
        cqtr = cset(67108864, 0, 0, 0, 0);

        tbl[0]  = '{1'b1, 1'b1, cid,  cid,  16'sd1000,   16'sd1000};
        tbl[1]  = '{1'b0, 1'b1, cid,  cid,  -16'sd2500,  -16'sd2500};
        tbl[2]  = '{1'b1, 1'b1, cimp, cid,  16'sd16000,  16'sd0};
        tbl[3]  = '{1'b0, 1'b1, cimp, cid,  16'sd0,      16'sd8000};
        tbl[4]  = '{1'b0, 1'b1, cimp, cid,  16'sd0,      16'sd0};
        tbl[5]  = '{1'b1, 1'b1, crec, cid,  16'sd1024,   16'sd1024};
        tbl[6]  = '{1'b0, 1'b1, crec, cid,  16'sd0,      16'sd512};
        tbl[7]  = '{1'b0, 1'b1, crec, cid,  16'sd0,      16'sd256};
        tbl[8]  = '{1'b1, 1'b1, csat, cid,  16'sd16000,  16'sd32767};
        tbl[9]  = '{1'b0, 1'b1, csat, cid,  -16'sd16000, -16'sd32768};
        // Stage 0 clamps to 32767 before stage 1 scales by 0.25.
        tbl[10] = '{1'b1, 1'b1, csat, cqtr, 16'sd16000,  16'sd8191};
        tbl[11] = '{1'b0, 1'b0, csat, cqtr, -16'sd7,     -16'sd7};
        tbl[12] = '{1'b0, 1'b1, crec, cid,  16'sd1024,   16'sd1024};
        tbl[13] = '{1'b0, 1'b1, crec, cid,  16'sd0,      16'sd512};
        tbl[14] = '{1'b0, 1'b1, crec, cid,  16'sd0,      16'sd256};

        do_reset();
        chk("reset_ready",   longint'(o_ready),   1);
        chk("reset_valid",   longint'(o_valid),   0);
        chk("reset_overrun", longint'(o_overrun), 0);
        chk("reset_data",    longint'(o_data),    0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) do_reset();
            i_coef = {tbl[i].c1, tbl[i].c0};
            run_sample(tbl[i].d, tbl[i].en, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
            chk($sformatf("tbl%0d_data", i), got, longint'(tbl[i].exp));
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].en ? 13 : 1);
            chk($sformatf("tbl%0d_ready_k", i), rdy_k, tbl[i].en ? 14 : 2);
            chk($sformatf("tbl%0d_nvalid", i), nvld, 1);
            chk($sformatf("tbl%0d_no_overrun", i), longint'(ovr_ok), 1);
        end

        // Overrun three cycles after accept: flagged, dropped, history untouched.
        i_coef = {cid, crec};
        do_reset();
        run_sample(16'sd1024, 1'b1, 3, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("ovr_pulse", longint'(ovr_ok), 1);
        chk("ovr_data", got, 1024);
        chk("ovr_lat", lat, 13);
        run_sample(16'sd0, 1'b1, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("ovr_next1", got, 512);
        run_sample(16'sd0, 1'b1, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("ovr_next2", got, 256);

        // Reset five cycles after accept aborts the sample and clears history.
        i_coef = {cid, cimp};
        do_reset();
        run_sample(16'sd16000, 1'b1, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("rst_pre", got, 0);
        run_sample(16'sd5000, 1'b1, 0, 5, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("rst_nvalid", nvld, 0);
        chk("rst_ready_k", rdy_k, 6);
        chk("rst_data_cleared", longint'(o_data), 0);
        run_sample(16'sd7000, 1'b1, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("rst_hist1", got, 0);
        run_sample(16'sd0, 1'b1, 0, 0, 1'b0, '0, got, lat, rdy_k, nvld, ovr_ok);
        chk("rst_hist2", got, 3500);

        // Random samples, coefficients and bypasses against the reference model.
        do_reset();
        cur_coef = rand_coef();
        i_coef   = cur_coef;
        for (int i = 0; i < 40; i++) begin
            rd       = 16'($urandom);
            ren      = ($urandom_range(0, 7) != 0);
            rchg     = ($urandom_range(0, 3) == 0);
            new_coef = rand_coef();
            exp_y    = model_step(cur_coef, int'(rd), ren);
            run_sample(rd, ren, 0, 0, rchg, new_coef, got, lat, rdy_k, nvld, ovr_ok);
            chk($sformatf("rand%0d_data", i), got, exp_y);
            chk($sformatf("rand%0d_lat", i), lat, ren ? 13 : 1);
            if (rchg) cur_coef = new_coef;
            repeat ($urandom_range(0, 2)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
